// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared state encoding and sizing helper for the FIFO drain arbiter
package fifo_pkg;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OUT     = 2'd3
  } drain_state_e;

  // Cycles a port stays ineligible after its read strobe (empty flag lags count by one).
  localparam logic [1:0] STALE_CYCLES = 2'd2;

  // Index width for n ports; never below 1 so a 2-port build still has a real bit.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin pick, searching from the port after ptr
module rr_select
  import fifo_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int cand;

  // ptr itself is visited last, so a lone requester at ptr still wins after a full lap.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!valid && req[cand]) begin
        valid       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// rtl/fifo_drain_arbiter.sv - drains N source FIFOs round-robin with bursts into one valid/ready stream
module fifo_drain_arbiter
  import fifo_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [N_PORTS-1:0]              fifo_empty,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   fifo_data,
  output logic [N_PORTS-1:0]              fifo_rd_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [idx_width(N_PORTS)-1:0]   m_port,
  output logic                            busy
);

  localparam int IW = idx_width(N_PORTS);
  localparam int BW = 4;

  drain_state_e          state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [N_PORTS-1:0]    sel_oh_q, sel_oh_d;
  logic [BW-1:0]         burst_q, burst_d;
  logic [1:0]            stale_q [N_PORTS];
  logic [1:0]            stale_d [N_PORTS];
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [IW-1:0]         m_port_q, m_port_d;

  logic [N_PORTS-1:0]    eligible;
  logic [N_PORTS-1:0]    rr_grant;
  logic [IW-1:0]         rr_idx;
  logic                  rr_valid;
  logic                  keep_burst;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      eligible[i] = !fifo_empty[i] && (stale_q[i] == 2'd0);
    end
  end

  rr_select #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_rr_select (
    .req   (eligible),
    .ptr   (ptr_q),
    .grant (rr_grant),
    .idx   (rr_idx),
    .valid (rr_valid)
  );

  // burst_q == 0 only after reset, where the first grant must come from the rotation.
  assign keep_burst = (burst_q != '0) && (burst_q < BW'(BURST_MAX)) && eligible[ptr_q];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_oh_d  = sel_oh_q;
    burst_d   = burst_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_port_d  = m_port_q;
    case (state_q)
      ST_ARB: begin
        if (enable && (keep_burst || rr_valid)) begin
          state_d = ST_ISSUE;
          if (keep_burst) begin
            burst_d = burst_q + 1'b1;
          end else begin
            ptr_d    = rr_idx;
            sel_oh_d = rr_grant;
            burst_d  = BW'(1);
          end
        end
      end
      ST_ISSUE: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        m_data_d  = fifo_data[ptr_q*DATA_WIDTH +: DATA_WIDTH];
        m_port_d  = ptr_q;
        m_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      stale_d[i] = stale_q[i];
      if (state_q == ST_ISSUE && sel_oh_q[i]) begin
        stale_d[i] = STALE_CYCLES;
      end else if (stale_q[i] != 2'd0) begin
        stale_d[i] = stale_q[i] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARB;
      ptr_q     <= IW'(N_PORTS - 1);
      sel_oh_q  <= '0;
      burst_q   <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_port_q  <= '0;
      for (int i = 0; i < N_PORTS; i++) stale_q[i] <= 2'd0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_oh_q  <= sel_oh_d;
      burst_q   <= burst_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_port_q  <= m_port_d;
      for (int i = 0; i < N_PORTS; i++) stale_q[i] <= stale_d[i];
    end
  end

  assign fifo_rd_en = (state_q == ST_ISSUE) ? sel_oh_q : '0;
  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_port     = m_port_q;
  assign busy       = (state_q != ST_ARB);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// tb/tb_fifo_drain_arbiter.sv - scoreboard bench with FIFO models and a grant-order reference
module tb_fifo_drain_arbiter;

  localparam int NP    = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           enable;
  logic [NP-1:0]  fifo_empty;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0]  fifo_rd_en;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;
  logic [1:0]     m_port;
  logic           busy;

  fifo_drain_arbiter #(
    .N_PORTS    (NP),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BURST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_port     (m_port),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q [NP][$];
  logic [7:0] rd_word [NP];
  int         n_rd_port [NP];
  int         n_out = 0;
  int         n_pushed = 0;
  int         ref_last = NP - 1;
  int         ref_run = 0;
  int         sb_port [$];
  logic [7:0] sb_data [$];
  bit         refill_mode = 0;
  bit         rand_mode = 0;
  int         refills_left = 0;
  int         refill_pend = 0;
  int         rand_budget = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Next grant from the arbitration rules: continue a burst while allowed, else rotate.
  function automatic int predict(input logic [NP-1:0] elig);
    int p;
    if (ref_run > 0 && ref_run < BURST && elig[ref_last]) begin
      ref_run++;
      return ref_last;
    end
    for (int i = 1; i <= NP; i++) begin
      p = (ref_last + i) % NP;
      if (elig[p]) begin
        ref_last = p;
        ref_run  = 1;
        return p;
      end
    end
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NP; i++) if (q[i].size() != 0) return 0;
    return 1;
  endfunction

  // Source FIFO models; flags driven here reflect the state the DUT sampled last edge.
  initial begin
    int p;
    int pp;
    logic [7:0] w;
    fifo_empty = '1;
    fifo_data  = '0;
    for (int i = 0; i < NP; i++) begin
      rd_word[i]   = 8'h00;
      n_rd_port[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (refill_pend > 0) begin
        refill_pend--;
        if (refill_pend == 0) q[2].push_back(8'hC3);
      end
      if (!rst && fifo_rd_en != '0) begin
        chk("rd_onehot", $countones(fifo_rd_en), 1);
        p = 0;
        for (int i = 0; i < NP; i++) if (fifo_rd_en[i]) p = i;
        pp = predict(~fifo_empty);
        chk("grant_port", p, pp);
        chk("rd_nonempty", (q[p].size() > 0), 1);
        if (q[p].size() > 0) begin
          rd_word[p] = q[p].pop_front();
          sb_port.push_back(p);
          sb_data.push_back(rd_word[p]);
        end
        n_rd_port[p]++;
        if (refill_mode && p == 2 && refills_left > 0) begin
          refills_left--;
          refill_pend = 1;
        end
      end
      if (rand_mode && rand_budget > 0 && $urandom_range(0, 3) == 0) begin
        w = 8'($urandom);
        q[$urandom_range(0, NP-1)].push_back(w);
        rand_budget--;
        n_pushed++;
      end
      for (int i = 0; i < NP; i++) begin
        fifo_empty[i]        = (q[i].size() == 0);
        fifo_data[i*DW +: DW] = rd_word[i];
      end
    end
  end

  // Output monitor: compares each handshake against the scoreboard, checks hold stability.
  initial begin
    bit         holding;
    logic [7:0] held_d;
    logic [1:0] held_p;
    int         ep;
    logic [7:0] ed;
    holding = 0;
    held_d  = '0;
    held_p  = '0;
    forever begin
      @(negedge clk);
      if (!rst && m_valid) begin
        if (holding) begin
          chk("hold_data", m_data, held_d);
          chk("hold_port", m_port, held_p);
        end
        if (m_ready) begin
          if (sb_port.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            ep = sb_port.pop_front();
            ed = sb_data.pop_front();
            chk("out_data", m_data, ed);
            chk("out_port", m_port, ep);
          end
          n_out++;
          holding = 0;
        end else begin
          holding = 1;
          held_d  = m_data;
          held_p  = m_port;
        end
      end else begin
        holding = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_rd(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (fifo_rd_en != '0) break;
      tick();
    end
    chk(name, (k < 200), 1);
  endtask

  task automatic wait_valid(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      if (m_valid) break;
      tick();
    end
    chk(name, (k < 200), 1);
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 4000; k++) begin
      if (all_empty() && sb_port.size() == 0 && !m_valid && !busy && refill_pend == 0) break;
      tick();
    end
    chk(name, (k < 4000), 1);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    sb_port.delete();
    sb_data.delete();
    ref_last = NP - 1;
    ref_run  = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic clear_counts();
    n_out = 0;
    for (int i = 0; i < NP; i++) n_rd_port[i] = 0;
  endtask

  initial begin
    int n0;
    rst     = 1'b1;
    enable  = 1'b0;
    m_ready = 1'b0;
    repeat (3) tick();
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_data", m_data, 0);
    chk("rst_port", m_port, 0);
    rst    = 1'b0;
    enable = 1'b1;
    tick();

    // Single port, two words, latency of two cycles from read strobe to valid.
    clear_counts();
    m_ready = 1'b1;
    q[1].push_back(8'h11);
    q[1].push_back(8'h22);
    wait_rd("t1_wait_rd");
    chk("t1_rd_bit", fifo_rd_en, 4'b0010);
    tick();
    chk("t1_lat_capture", m_valid, 0);
    tick();
    chk("t1_lat_out", m_valid, 1);
    chk("t1_first_data", m_data, 8'h11);
    chk("t1_first_port", m_port, 1);
    drain("t1_drain");
    chk("t1_reads", n_rd_port[1], 2);
    chk("t1_words", n_out, 2);

    // All ports full: bursts of four per port, 32 words.
    reset_dut();
    clear_counts();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 8; k++) q[p].push_back(8'(p * 16 + k));
    wait_rd("t2_wait_rd");
    chk("t2_first_grant", fifo_rd_en, 4'b0001);
    drain("t2_drain");
    chk("t2_words", n_out, 32);
    for (int p = 0; p < NP; p++) chk("t2_reads_per_port", n_rd_port[p], 8);

    // Backpressure: word held stable for ten cycles with no further reads.
    m_ready = 1'b0;
    q[3].push_back(8'hA5);
    wait_valid("t3_wait_valid");
    q[0].push_back(8'h5A);
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_data", m_data, 8'hA5);
      chk("t3_hold_port", m_port, 3);
      chk("t3_no_rd", fifo_rd_en, 0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("t3_after_hs", m_valid, 0);
    drain("t3_drain");

    // enable dropped in CAPTURE: word still delivered, then idle.
    q[0].push_back(8'h31);
    q[0].push_back(8'h32);
    q[1].push_back(8'h41);
    n0 = n_out;
    wait_rd("t4_wait_rd");
    tick();
    enable = 1'b0;
    for (int k = 0; k < 50 && n_out == n0; k++) tick();
    chk("t4_delivered", n_out, n0 + 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_rd", fifo_rd_en, 0);
    end
    enable = 1'b1;
    drain("t4_drain");

    // Reset while holding a word in OUT.
    m_ready = 1'b0;
    q[1].push_back(8'h77);
    wait_valid("t5_wait_valid");
    q[0].push_back(8'h01);
    q[2].push_back(8'h02);
    tick();
    rst = 1'b1;
    sb_port.delete();
    sb_data.delete();
    ref_last = NP - 1;
    ref_run  = 0;
    tick();
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_busy", busy, 0);
    rst     = 1'b0;
    m_ready = 1'b1;
    wait_rd("t5_wait_rd");
    chk("t5_first_grant", fifo_rd_en, 4'b0001);
    drain("t5_drain");

    // Single word on port 2 refilled one cycle after its read.
    reset_dut();
    clear_counts();
    refill_mode  = 1;
    refills_left = 1;
    q[2].push_back(8'h33);
    drain("t6_drain");
    chk("t6_reads", n_rd_port[2], 2);
    chk("t6_words", n_out, 2);
    refill_mode = 0;

    // Randomized traffic with random backpressure and enable.
    reset_dut();
    clear_counts();
    n_pushed = 0;
    for (int k = 0; k < 20; k++) begin
      q[$urandom_range(0, NP-1)].push_back(8'($urandom));
      n_pushed++;
    end
    rand_budget = 150;
    rand_mode   = 1;
    for (int k = 0; k < 2500; k++) begin
      tick();
      m_ready = ($urandom_range(0, 9) < 7);
      enable  = ($urandom_range(0, 9) < 9);
    end
    rand_mode = 0;
    enable    = 1'b1;
    m_ready   = 1'b1;
    tick();
    drain("t7_drain");
    chk("t7_words", n_out, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_drain_arbiter.md
FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
REQ-001 SHALL have parameter N_PORTS, default 4, number of source FIFOs drained (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each FIFO data word.
REQ-003 SHALL have parameter BURST_MAX, default 4, maximum consecutive grants to one port before rotating (1..15).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  when low, no new grant is started; an in-flight transfer completes.
REQ-007 fifo_empty  input  N_PORTS  empty flag of each source FIFO, bit i = port i.
REQ-008 fifo_data  input  N_PORTS*DATA_WIDTH  registered read data of each FIFO, port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 fifo_rd_en  output  N_PORTS  one-hot-or-zero read strobe to the source FIFOs.
REQ-010 m_valid  output  1  output word valid.
REQ-011 m_ready  input  1  downstream accepts the word when m_valid and m_ready are both high.
REQ-012 m_data  output  DATA_WIDTH  drained word.
REQ-013 m_port  output  clog2(N_PORTS)  index of the port m_data came from.
REQ-014 busy  output  1  high in any state other than ARB.

Function
REQ-015 SHALL implement the FSM ARB -> ISSUE -> CAPTURE -> OUT -> ARB.
REQ-016 ARB: if enable and any eligible port exists, SHALL select one round-robin, starting from the port after the last granted, and go to ISSUE; otherwise SHALL stay in ARB.
REQ-017 Eligible port: fifo_empty bit low and not masked under REQ-022.
REQ-018 ISSUE: SHALL drive fifo_rd_en bit of the selected port high for exactly one cycle; all other bits low.
REQ-019 CAPTURE: SHALL register fifo_data of the selected port into m_data and its index into m_port; m_valid SHALL rise on the following edge (rd_en in cycle t -> m_valid high from cycle t+2).
REQ-020 OUT: m_valid, m_data and m_port SHALL stay stable until m_ready is high; on handshake SHALL drop m_valid and return to ARB on the same edge.
REQ-021 Burst: if the granted port is still eligible and its consecutive-grant count < BURST_MAX, ARB SHALL grant it again; at BURST_MAX the pointer SHALL advance even if it is the only eligible port, then re-grant it if no other port is eligible.
REQ-022 Flag staleness: a port SHALL be ineligible for the 2 cycles after its rd_en pulse, because the FIFO empty flag lags its count by one cycle.
REQ-023 Simultaneous requests SHALL be resolved purely by the round-robin pointer; no port SHALL be starved beyond (N_PORTS-1)*BURST_MAX grants.
REQ-024 enable dropping during ISSUE, CAPTURE or OUT SHALL NOT abort the transfer.
REQ-025 fifo_rd_en SHALL never be asserted to a port whose fifo_empty was high in the preceding ARB cycle.

Reset
REQ-026 On rst: state ARB, fifo_rd_en 0, m_valid 0, m_data 0, m_port 0, busy 0, round-robin pointer at port N_PORTS-1 (so port 0 is granted first), burst count 0, masks clear.
REQ-027 Reset asserted mid-transfer SHALL discard the in-flight word; the word popped from the FIFO is lost by design.

Structure
REQ-028 State encoding enum and the index-width function SHALL live in the shared package fifo_pkg.
REQ-029 Round-robin selection SHALL be a sub-module rr_select (request vector, pointer -> one-hot grant plus index), purely combinational.

Verification
REQ-030 Port 1 only non-empty, holding 0x11, 0x22; m_ready=1 -> rd_en[1] pulses 2 times; m_data 0x11 then 0x22; m_port=1; m_valid first high 2 cycles after the first rd_en.
REQ-031 All 4 ports non-empty, 8 words each, BURST_MAX=4 -> grant order 0,0,0,0,1,1,1,1,2,...; 32 words out; no rd_en to an empty port.
REQ-032 Word 0xA5 at OUT, m_ready held low for 10 cycles -> m_valid, m_data=0xA5 and m_port stable; no further rd_en; handshake on cycle 11.
REQ-033 enable low while in CAPTURE -> current word delivered; then the FSM stays in ARB and busy=0 until enable returns.
REQ-034 rst asserted in OUT -> next cycle m_valid=0, busy=0; after release, port 0 is granted first.
REQ-035 Port 2 holding a single word, refilled by one write one cycle after its rd_en -> exactly one read in each case; no read while the FIFO is empty.
